fr_pipe_out_buffer: RTL and testbench
=====================================

// Module: fr_pipe_out_buffer
// PURPOSE
//  Streams 32-bit spindle firing-rate samples (f_*fr_Ia / f_*fr_II) to the host.
//  Captures one sample per sim_clk tick into a FIFO.
//  Serves the FIFO to an okBTPipeOut as 16-bit words, low half first.
//  Host-bound counterpart of the pipe-in waveform feeder; runs entirely on ti_clk.
// PARAMETERS
//  ADDR_W       9    FIFO address width; depth = 2**ADDR_W 32-bit samples
//  BLOCK_WORDS  256  16-bit words required before ep_ready asserts (BTPipe block size)
// PORTS
//  clk           in   1   ti_clk; only clock
//  reset_n       in   1   asynchronous, active-low reset
//  clear         in   1   synchronous FIFO flush, active high
//  enable        in   1   1 = capture samples; 0 = ticks ignored
//  sample_tick   in   1   sim_clk from another domain; rising edge = new sample
//  sample_in     in   32  sample value; stable >=4 clk after each sample_tick rise
//  ep_read       in   1   okBTPipeOut read strobe; one word consumed per high cycle
//  ep_datain     out  16  word presented to okBTPipeOut
//  ep_ready      out  1   1 when word_count >= BLOCK_WORDS
//  word_count    out  ADDR_W+2  16-bit words available (2 x samples, minus 1 if high half pending)
//  overflow      out  1   sticky: sample dropped because FIFO full
//  underflow     out  1   sticky: ep_read while empty
// BEHAVIOUR
//  Reset (reset_n=0, async)
//   - Pointers, half-select, word_count, ep_ready, overflow, underflow, sync flops = 0.
//   - ep_datain = 16'h0000.
//   - FIFO RAM contents are don't-care.
//  Tick capture
//   - sample_tick passes a 2-flop synchroniser plus a third flop for edge detect.
//   - Rising edge detected on the cycle the 2nd flop goes 1 while the 3rd flop is 0.
//   - In that same cycle sample_in is written if enable=1 and clear=0.
//   - Capture latency: 3 clk from the sample_tick rise.
//   - Held-high tick = one capture only.
//  Full
//   - Write dropped; wr_ptr unchanged; overflow <= 1.
//  Read
//   - First-word-fall-through: ep_datain = head[15:0] when half=0, head[31:16] when half=1.
//   - ep_read with half=0: half <= 1.
//   - ep_read with half=1: half <= 0 and pop (rd_ptr+1).
//   - Empty: ep_datain = 0; ep_read sets underflow; no state change.
//  Simultaneous
//   - Capture and pop in the same cycle: both occur; sample count unchanged.
//   - Capture into an empty FIFO becomes visible on ep_datain the next cycle.
//  Pointers
//   - ADDR_W+1 bits each; wrap naturally.
//   - full: MSBs differ and lower bits equal.
//   - empty: pointers equal.
//  ep_ready
//   - Registered; updates one cycle after the word_count change.
//  clear
//   - Pointers, half and flags <= 0 next edge.
//   - Has priority over capture and ep_read in the same cycle.
//  Mid-block reset
//   - Resets everything; host restarts the transfer.
//   - No partial-word state survives.
// TESTING
//  1. Reset, then 1 tick with sample_in=32'h3F66_6666 -> 3 clk later word_count=2;
//     reads give 16'h6666 then 16'h3F66; then empty.
//  2. Tick held high for 20 clk -> exactly one sample captured.
//  3. Fill 512 samples, then 1 more tick -> overflow=1, word_count=1024;
//     the 513th sample is absent on readback.
//  4. word_count=255 -> ep_ready=0; one more tick -> ep_ready=1 one clk after count=257.
//  5. Capture and pop (ep_read on high half) in the same cycle, FIFO holding 3 samples
//     -> sample count stays 3; data order intact.
//  6. ep_read on empty -> ep_datain=0, underflow=1;
//     then clear -> underflow=0, word_count=0.

Source files
------------

// File: rtl/fr_pipe_out_buffer.sv
// Host-bound firing-rate sample FIFO: captures one 32-bit sample per sim_clk
// rising edge and serves it to okBTPipeOut as 16-bit words, low half first.
module fr_pipe_out_buffer #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned BLOCK_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              enable,
    input  logic              sample_tick,
    input  logic [31:0]       sample_in,
    input  logic              ep_read,
    output logic [15:0]       ep_datain,
    output logic              ep_ready,
    output logic [ADDR_W+1:0] word_count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W+1:0] READY_LVL = BLOCK_WORDS[ADDR_W+1:0];

    logic [31:0]     mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] fill;
    logic            half;
    logic            tick_s1;
    logic            tick_s2;
    logic            tick_s3;
    logic            tick_rise;
    logic            full;
    logic            empty;
    logic            do_write;
    logic            do_read;
    logic [31:0]     head;

    assign tick_rise = tick_s2 & ~tick_s3;
    assign full      = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                       (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign do_write  = tick_rise && enable && !clear && !full;
    assign do_read   = ep_read && !clear && !empty;
    assign fill      = wr_ptr - rd_ptr;
    assign head      = mem[rd_ptr[ADDR_W-1:0]];

    // A pending high half means the low word of the head sample is already gone.
    assign word_count = {fill, 1'b0} - {{(ADDR_W+1){1'b0}}, half};

    always_comb begin
        ep_datain = '0;
        if (!empty) begin
            ep_datain = half ? head[31:16] : head[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[ADDR_W-1:0]] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_s1   <= 1'b0;
            tick_s2   <= 1'b0;
            tick_s3   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            half      <= 1'b0;
            ep_ready  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            tick_s1 <= sample_tick;
            tick_s2 <= tick_s1;
            tick_s3 <= tick_s2;
            if (clear) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                half      <= 1'b0;
                ep_ready  <= 1'b0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                ep_ready <= (word_count >= READY_LVL);
                if (do_write) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (tick_rise && enable && full) begin
                    overflow <= 1'b1;
                end
                if (ep_read && empty) begin
                    underflow <= 1'b1;
                end
                if (do_read) begin
                    half <= ~half;
                    if (half) begin
                        rd_ptr <= rd_ptr + PTR_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fr_pipe_out_buffer.sv
// Scoreboard bench for fr_pipe_out_buffer: a sample-queue model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_fr_pipe_out_buffer;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned BLOCK  = 256;
    localparam int unsigned DEPTH  = 512;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        enable = 1'b0;
    logic        sample_tick = 1'b0;
    logic [31:0] sample_in = '0;
    logic        ep_read = 1'b0;
    logic [15:0] ep_datain;
    logic        ep_ready;
    logic [10:0] word_count;
    logic        overflow;
    logic        underflow;

    fr_pipe_out_buffer #(.ADDR_W(ADDR_W), .BLOCK_WORDS(BLOCK)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable),
        .sample_tick(sample_tick), .sample_in(sample_in), .ep_read(ep_read),
        .ep_datain(ep_datain), .ep_ready(ep_ready), .word_count(word_count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [10:0] wc;
        logic        rdy;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: FIFO contents as a queue of whole samples.
    logic [31:0] m_q[$];
    logic        m_half, m_rdy, m_ovf, m_unf;
    logic        m_t1, m_t2, m_t3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        logic [31:0] h;
        int w;
        h = (m_q.size() == 0) ? 32'h0 : m_q[0];
        e.data = (m_q.size() == 0) ? 16'h0 : (m_half ? h[31:16] : h[15:0]);
        w = 2 * m_q.size() - int'(m_half);
        e.wc  = 11'(w);
        e.rdy = m_rdy;
        e.ovf = m_ovf;
        e.unf = m_unf;
        return e;
    endfunction

    task automatic model_init();
        m_q.delete();
        m_half = 0; m_rdy = 0; m_ovf = 0; m_unf = 0;
        m_t1 = 0; m_t2 = 0; m_t3 = 0;
    endtask

    task automatic step(input logic tk, input logic [31:0] sin, input logic rd,
                        input logic clr, input logic en);
        exp_t e;
        logic rise, emp, is_full;
        @(posedge clk); #1;
        reset_n = 1'b1;
        sample_tick = tk; sample_in = sin; ep_read = rd; clear = clr; enable = en;
        e = predict();
        exp_q.push_back(e);
        // A tick rise is captured on the third edge after it appears.
        rise    = m_t2 && !m_t3;
        emp     = (m_q.size() == 0);
        is_full = (m_q.size() == DEPTH);
        if (clr) begin
            m_q.delete();
            m_half = 0; m_rdy = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (rd && emp) m_unf = 1;
            if (rd && !emp) begin
                if (m_half) begin
                    void'(m_q.pop_front());
                    m_half = 0;
                end else begin
                    m_half = 1;
                end
            end
            if (rise && en) begin
                if (is_full) m_ovf = 1;
                else m_q.push_back(sin);
            end
            m_rdy = (e.wc >= 11'(BLOCK));
        end
        m_t3 = m_t2; m_t2 = m_t1; m_t1 = tk;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            reset_n = 1'b0;
            sample_tick = 0; ep_read = 0; clear = 0; enable = 0; sample_in = '0;
            model_init();
            exp_q.push_back(predict());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, sample_in, 0, 0, 1);
    endtask

    task automatic reads(input int n);
        for (int i = 0; i < n; i++) step(0, sample_in, 1, 0, 1);
    endtask

    task automatic tick_sample(input logic [31:0] v);
        step(1, v, 0, 0, 1);
        step(1, v, 0, 0, 1);
        step(0, v, 0, 0, 1);
        step(0, v, 0, 0, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("ep_datain",  32'(ep_datain),  32'(e.data));
                chk("word_count", 32'(word_count), 32'(e.wc));
                chk("ep_ready",   32'(ep_ready),   32'(e.rdy));
                chk("overflow",   32'(overflow),   32'(e.ovf));
                chk("underflow",  32'(underflow),  32'(e.unf));
            end
        end
    end

    initial begin : driver
        logic tk;
        logic [31:0] v;
        int cnt, rd_pct;
        model_init();

        // Single sample, read low then high half, then empty
        do_reset();
        tick_sample(32'h3F66_6666);
        idle(1);
        reads(2);
        idle(2);

        // Tick held high for 20 cycles captures once
        for (int i = 0; i < 20; i++) step(1, 32'hA5A5_1234, 0, 0, 1);
        idle(4);
        reads(2);
        idle(1);

        // Fill to full, then one extra tick is dropped
        for (int i = 0; i < DEPTH; i++) tick_sample($urandom);
        tick_sample(32'hDEAD_BEEF);
        idle(2);
        reads(2 * DEPTH);
        idle(2);

        // ep_ready threshold around 255/257 words
        for (int i = 0; i < 128; i++) tick_sample($urandom);
        reads(1);
        idle(3);
        tick_sample($urandom);
        idle(3);
        reads(257);
        idle(2);

        // Capture coinciding with a high-half pop
        for (int i = 0; i < 3; i++) tick_sample($urandom);
        idle(3);
        reads(1);
        v = $urandom;
        step(1, v, 0, 0, 1);
        step(1, v, 0, 0, 1);
        step(0, v, 1, 0, 1);
        idle(3);
        reads(6);
        idle(1);

        // Read on empty, then clear
        reads(1);
        idle(2);
        step(0, sample_in, 0, 1, 1);
        idle(2);

        // Reset in the middle of a block
        for (int i = 0; i < 10; i++) tick_sample($urandom);
        reads(3);
        do_reset();
        for (int i = 0; i < 2; i++) tick_sample($urandom);
        reads(4);
        idle(2);

        // Randomised traffic
        tk = 0; cnt = 2; v = $urandom;
        for (int i = 0; i < 4000; i++) begin
            rd_pct = (i < 2000) ? 8 : 60;
            if (cnt == 0) begin
                tk = ~tk;
                if (tk) v = $urandom;
                cnt = $urandom_range(2, 4);
            end
            cnt--;
            step(tk, v, ($urandom_range(0, 99) < rd_pct),
                 ($urandom_range(0, 599) == 0), ($urandom_range(0, 29) != 0));
        end
        idle(3);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) chk("scoreboard_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
